// File: rtl/mandelbrot_escape_seq.sv
// rtl/mandelbrot_escape_seq.sv - sequential escape-time Mandelbrot engine, optional SIZE_EXPLORE_ZOUT_EN z output mux
module mandelbrot_escape_seq #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 8,
    parameter int MAX_ITER   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int FRAC = WIDTH - 3;
    localparam int W2   = 2 * WIDTH;
    // 4.0 expressed in the Q(2*FRAC) scale of the unshifted squares
    localparam logic [W2:0] ESC_LIM = (W2 + 1)'(1) << (2 * FRAC + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [W2-1:0]           r_sreg;
    logic signed [WIDTH-1:0] r_cr;
    logic signed [WIDTH-1:0] r_ci;
    logic signed [WIDTH-1:0] r_zr;
    logic signed [WIDTH-1:0] r_zi;
    logic [ITER_WIDTH-1:0]   r_count;
    logic                    r_escaped;

    logic                    w_start;
    logic                    w_shift;
    logic                    w_load;
    logic                    w_update;
    logic                    w_set_esc;
    logic                    w_escape;

    logic signed [W2-1:0]    w_zr2;
    logic signed [W2-1:0]    w_zi2;
    logic signed [W2-1:0]    w_zrzi;
    logic [W2:0]             w_mag;
    logic signed [W2:0]      w_diff;
    logic signed [W2:0]      w_diff_sh;
    logic signed [W2:0]      w_cross2;
    logic signed [W2:0]      w_cross_sh;
    logic [WIDTH-1:0]        w_zr_next;
    logic [WIDTH-1:0]        w_zi_next;

    assign w_shift = ui_in[1];
    assign w_start = ui_in[2];

    // Full-precision products; squares are non-negative so the magnitude sum is unsigned
    assign w_zr2      = W2'(r_zr) * W2'(r_zr);
    assign w_zi2      = W2'(r_zi) * W2'(r_zi);
    assign w_zrzi     = W2'(r_zr) * W2'(r_zi);
    assign w_mag      = {1'b0, w_zr2} + {1'b0, w_zi2};
    assign w_escape   = (w_mag > ESC_LIM);

    // Arithmetic shifts truncate toward -inf; the W-bit slices wrap on overflow
    assign w_diff     = (W2 + 1)'(w_zr2) - (W2 + 1)'(w_zi2);
    assign w_diff_sh  = w_diff >>> FRAC;
    assign w_cross2   = ((W2 + 1)'(w_zrzi)) <<< 1;
    assign w_cross_sh = w_cross2 >>> FRAC;
    assign w_zr_next  = w_diff_sh[WIDTH-1:0] + r_cr;
    assign w_zi_next  = w_cross_sh[WIDTH-1:0] + r_ci;

    // State register; ena low freezes the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control: escape beats the iteration limit, which beats an update
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_update     = 1'b0;
        w_set_esc    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_escape) begin
                    w_set_esc    = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_count == ITER_WIDTH'(MAX_ITER)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_update = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand shift register and iteration datapath; c is taken from sreg before this cycle's shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg    <= '0;
            r_cr      <= '0;
            r_ci      <= '0;
            r_zr      <= '0;
            r_zi      <= '0;
            r_count   <= '0;
            r_escaped <= 1'b0;
        end else if (ena) begin
            if (w_shift) begin
                r_sreg <= {r_sreg[W2-2:0], ui_in[0]};
            end
            if (w_load) begin
                r_cr      <= r_sreg[WIDTH-1:0];
                r_ci      <= r_sreg[W2-1:WIDTH];
                r_zr      <= '0;
                r_zi      <= '0;
                r_count   <= '0;
                r_escaped <= 1'b0;
            end else if (w_update) begin
                r_zr    <= w_zr_next;
                r_zi    <= w_zi_next;
                r_count <= r_count + 1'b1;
            end else if (w_set_esc) begin
                r_escaped <= 1'b1;
            end
        end
    end

    assign uio_oe = 8'hFF;

`ifdef SIZE_EXPLORE_ZOUT_EN
    logic w_unused;
    assign w_unused = &{1'b0, uio_in, ui_in[6:3]};
    assign uo_out   = ui_in[7] ? r_zr[WIDTH-1:WIDTH-8] : 8'(r_count);
    assign uio_out  = {(r_state == S_RUN), (r_state == S_DONE), r_escaped,
                       (ui_in[7] ? r_zi[WIDTH-1:WIDTH-5] : 5'b0)};
`else
    logic w_unused;
    assign w_unused = &{1'b0, uio_in, ui_in[7:3]};
    assign uo_out   = 8'(r_count);
    assign uio_out  = {(r_state == S_RUN), (r_state == S_DONE), r_escaped, 5'b0};
`endif

endmodule

// File: tb/tb_mandelbrot_escape_seq.sv
// tb/tb_mandelbrot_escape_seq.sv - scoreboard bench for mandelbrot_escape_seq
module tb_mandelbrot_escape_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cnt;
        int esc;
        int cycles;
    } exp_t;

    exp_t q[$];

    mandelbrot_escape_seq #(
        .WIDTH(8),
        .ITER_WIDTH(8),
        .MAX_ITER(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ui_in(ui_in),
        .uo_out(uo_out),
        .uio_in(uio_in),
        .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            ui_in[0] = b[i];
            ui_in[1] = 1'b1;
            tick();
        end
        ui_in[1] = 1'b0;
        ui_in[0] = 1'b0;
    endtask

    task automatic start_run();
        ui_in[2] = 1'b1;
        tick();
        ui_in[2] = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (uio_out[6] && !uio_out[7]) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_done_timeout"}, ok, 1);
    endtask

    // Monitor: counts busy cycles and checks each completed run against the scoreboard
    initial begin
        int  busy_n;
        logic prev_done;
        exp_t e;
        busy_n    = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_n    = 0;
                prev_done = 1'b0;
            end else begin
                if (uio_out[7]) busy_n++;
                if (uio_out[6] && !prev_done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("sb_count", int'(uo_out), e.cnt);
                        chk("sb_escaped", int'(uio_out[5]), e.esc);
                        chk("sb_busy_cycles", busy_n, e.cycles);
                        chk("sb_low_bits", int'(uio_out[4:0]), 0);
                    end
                    busy_n = 0;
                end
                prev_done = uio_out[6];
            end
        end
    end

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) tick();
        chk("reset_uo_out", int'(uo_out), 0);
        chk("reset_uio_out", int'(uio_out), 0);
        chk("reset_uio_oe", int'(uio_oe), 8'hFF);
        rst_n = 1'b1;
        tick();

        // ena low: start must not move the FSM
        ena      = 1'b0;
        ui_in[2] = 1'b1;
        repeat (3) tick();
        chk("ena0_uio_out", int'(uio_out), 0);
        chk("ena0_uo_out", int'(uo_out), 0);
        ui_in[2] = 1'b0;
        ena      = 1'b1;
        tick();

        // ci=0, cr=3.0: one update then escape
        shift_byte(8'h00);
        shift_byte(8'h60);
        e = '{cnt: 1, esc: 1, cycles: 2};
        q.push_back(e);
        start_run();
        wait_done("run_c3");
`ifdef SIZE_EXPLORE_ZOUT_EN
        ui_in[7] = 1'b1;
        #1;
        chk("zout_zr", int'(uo_out), 8'h60);
        chk("zout_zi", int'(uio_out[4:0]), 0);
        ui_in[7] = 1'b0;
        #1;
`endif

        // Shifting during DONE leaves the held result intact
        shift_byte(8'h00);
        shift_byte(8'h00);
        chk("done_hold_count", int'(uo_out), 1);
        chk("done_hold_flags", int'(uio_out[7:5]), 3'b011);

        // c=0 never escapes: full 256-cycle run
        e = '{cnt: 255, esc: 0, cycles: 256};
        q.push_back(e);
        start_run();
        wait_done("run_c0");

        // c=-1: z oscillates 0/-1
        shift_byte(8'h00);
        shift_byte(8'hE0);
        e = '{cnt: 255, esc: 0, cycles: 256};
        q.push_back(e);
        start_run();
        wait_done("run_cm1");

        // Same c with ena low for 10 cycles mid-run
        e = '{cnt: 255, esc: 0, cycles: 266};
        q.push_back(e);
        start_run();
        repeat (20) tick();
        ena = 1'b0;
        repeat (10) tick();
        chk("ena0_midrun_busy", int'(uio_out[7]), 1);
        ena = 1'b1;
        wait_done("run_cm1_ena");

        // Reset asserted mid-run clears outputs asynchronously
        shift_byte(8'h00);
        shift_byte(8'h00);
        start_run();
        repeat (50) tick();
        chk("midrun_busy", int'(uio_out[7]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", int'(uo_out), 0);
        chk("async_rst_uio_out", int'(uio_out), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        shift_byte(8'h00);
        shift_byte(8'h60);
        e = '{cnt: 1, esc: 1, cycles: 2};
        q.push_back(e);
        start_run();
        wait_done("run_after_rst");

        repeat (3) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
